ab_seq_gen: RTL

//   Stimulus transmitter for the a/b sequence-detector FSM. Accepts a burst request
//   and drives the a/b pattern 10 -> 01 -> 11 x LEN -> 00, which walks the detector
//   S0->S1->S2, holds it in S2 for LEN cycles and returns it to S0.
//   exp_y is the reference model of the detector's y output, used for self-checking.

---
 rtl/ab_seq_gen.sv | 86 ++++++++
 1 files changed

// File: rtl/ab_seq_gen.sv
// ab_seq_gen: a/b burst transmitter that walks the sequence detector S0->S1->S2, holds it, and returns it to S0
module ab_seq_gen #(
    parameter int LEN_W   = 4,
    parameter int GAP_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             exp_y,
    output logic             busy,
    output logic             done
);
    localparam int GW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM_A = 3'd1,
        ARM_B = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt, len, len_nxt;
    logic [GW-1:0]    gcnt, gcnt_nxt;

    // state, hold/gap counters and latched burst length
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            gcnt  <= '0;
            len   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gcnt  <= gcnt_nxt;
            len   <= len_nxt;
        end
    end

    // next-state: abort wins over the normal ARM/HOLD progression; unknown encodings fall back to IDLE
    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = cnt;
        gcnt_nxt  = gcnt;
        len_nxt   = len;
        case (state)
            IDLE: begin
                state_nxt = req_valid ? ARM_A : IDLE;
                len_nxt   = req_valid ? req_len : len;
            end
            ARM_A: state_nxt = abort ? FLUSH : ARM_B;
            ARM_B: begin
                state_nxt = (abort || len == '0) ? FLUSH : HOLD;
                cnt_nxt   = len;
            end
            HOLD: begin
                state_nxt = (abort || cnt == LEN_W'(1)) ? FLUSH : HOLD;
                cnt_nxt   = cnt - 1'b1;
            end
            FLUSH: begin
                state_nxt = (GAP_CYC != 0) ? GAP : IDLE;
                gcnt_nxt  = GW'(GAP_CYC);
            end
            GAP: begin
                state_nxt = (gcnt == GW'(1)) ? IDLE : GAP;
                gcnt_nxt  = gcnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign a         = (state == ARM_A) || (state == HOLD);
    assign b         = (state == ARM_B) || (state == HOLD);
    assign exp_y     = (state == HOLD);
    assign done      = (state == FLUSH);
    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE);
endmodule
